pipe_hazard_ctrl: RTL

Central stall/flush scheduler for the 5-stage RV32I pipeline. Drives hold/flush controls for the F, D, E and M pipeline registers and a writeback-bubble control for the W stage. Sources: load-use hazards, taken jumps/branches resolved in E, and a variable-latency data-memory handshake that it sequences with a small FSM. Sits beside the datapath, with one control output per pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/dmem_seq_fsm.sv | 65 ++++++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Used by dmem_seq_fsm and pipe_hazard_ctrl.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W        = 5;
  localparam int unsigned PERF_W           = 32;
  localparam int unsigned DEFAULT_MAX_WAIT = 15;
  localparam int unsigned DEFAULT_CNT_W    = 8;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // Data-memory handshake sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // One control bit per pipeline register, plus the W write suppression
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic w_bubble;
  } pipe_ctl_t;

  // True when an enabled source operand names the given destination register
  function automatic logic src_hits(
    input logic                 use_src,
    input logic [REG_IDX_W-1:0] src,
    input logic [REG_IDX_W-1:0] rd
  );
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/dmem_seq_fsm.sv
// Data-memory handshake sequencer: IDLE/WAIT/DONE with a bounded wait
// counter. Produces the held request, the timeout pulse and mem_stall.
module dmem_seq_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic M_mem_req,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_err,
  output logic mem_stall
);

  // Last count value before giving up on the ack
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  mem_state_e       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_err;

  // State, wait counter and timeout pulse; an ack outside WAIT is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_mem_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (M_mem_req) begin
            r_state    <= WAIT;
            r_wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            r_state <= DONE;
          end else if (r_wait_cnt == LAST_CNT) begin
            r_state   <= DONE;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Request is a pure state decode; stall also covers the IDLE detect cycle
  assign dmem_req  = (r_state == WAIT);
  assign mem_stall = ((r_state == IDLE) && M_mem_req) || (r_state == WAIT);
  assign mem_err   = r_mem_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: memory handshake stalls,
// taken jump/branch flushes and load-use interlocks, in that priority.
// Optional stall-cycle counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] D_rs1,
  input  logic [REG_IDX_W-1:0] D_rs2,
  input  logic                 D_use_rs1,
  input  logic                 D_use_rs2,
  input  logic [REG_IDX_W-1:0] E_rd,
  input  logic                 E_is_load,
  input  logic                 E_jb_taken,
  input  logic                 M_mem_req,
  input  logic                 dmem_ack,
  output logic                 dmem_req,
  output logic                 stall_F,
  output logic                 stall_D,
  output logic                 stall_E,
  output logic                 stall_M,
  output logic                 flush_D,
  output logic                 flush_E,
  output logic                 W_bubble,
  output logic                 mem_err,
  output logic [PERF_W-1:0]    stall_cycles
);

  logic      w_mem_stall;
  logic      w_load_use;
  pipe_ctl_t w_ctl;

  dmem_seq_fsm #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_dmem_seq (
    .clk       (clk),
    .rst       (rst),
    .M_mem_req (M_mem_req),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .mem_err   (mem_err),
    .mem_stall (w_mem_stall)
  );

  // A load in E feeding a source of D; x0 never creates a dependency
  assign w_load_use = E_is_load && (E_rd != REG_ZERO) &&
                      (src_hits(D_use_rs1, D_rs1, E_rd) ||
                       src_hits(D_use_rs2, D_rs2, E_rd));

  // Priority mux; everything is quiet while the core is in reset
  always_comb begin
    w_ctl = '0;
    if (!rst) begin
      if (w_mem_stall) begin
        w_ctl.stall_f  = 1'b1;
        w_ctl.stall_d  = 1'b1;
        w_ctl.stall_e  = 1'b1;
        w_ctl.stall_m  = 1'b1;
        w_ctl.w_bubble = 1'b1;
      end else if (E_jb_taken) begin
        // D holds a wrong-path instruction, so its hazard is irrelevant
        w_ctl.flush_d = 1'b1;
        w_ctl.flush_e = 1'b1;
      end else if (w_load_use) begin
        w_ctl.stall_f = 1'b1;
        w_ctl.stall_d = 1'b1;
        w_ctl.flush_e = 1'b1;
      end
    end
  end

  assign stall_F  = w_ctl.stall_f;
  assign stall_D  = w_ctl.stall_d;
  assign stall_E  = w_ctl.stall_e;
  assign stall_M  = w_ctl.stall_m;
  assign flush_D  = w_ctl.flush_d;
  assign flush_E  = w_ctl.flush_e;
  assign W_bubble = w_ctl.w_bubble;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cycles;

  // Saturating count of cycles in which fetch is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_ctl.stall_f && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule
